afe_sar_agc_ctrl: RTL and testbench

- Parametrised digital controller for the analog front end.
- Sequences an N-bit SAR conversion: sample phase, then bit trials driving the reference DAC control word, with the comparator decision as input.
- Converts each offset-binary result to two's complement and presents it with a valid strobe.
- Runs a windowed peak-detect AGC that drives a thermometer-coded VGA control word. It replaces the separate SAR tester, level-detect and VGA-control blocks with one generalised unit sitting between the analog top and the demodulator top.

---
 rtl/afe_pkg.sv | 31 +++
 rtl/afe_agc_loop.sv | 76 +++++++
 rtl/afe_sar_agc_ctrl.sv | 150 +++++++++++++++
 tb/tb_afe_sar_agc_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_pkg.sv
// Shared types and helpers for the AFE SAR / AGC controller:
// FSM state encoding, thermometer coding and saturated magnitude.
package afe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } afe_state_e;

  // Low idx bits set, never beyond width; callers truncate to their width.
  function automatic logic [31:0] thermometer(input int unsigned idx, input int unsigned width);
    logic [31:0] t;
    t = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      t[i[4:0]] = (i < idx) && (i < width);
    end
    return t;
  endfunction

  // Magnitude of a sign-extended w-bit sample, clamped to 2^(w-1)-1.
  function automatic int unsigned sat_abs(input logic signed [31:0] v, input int unsigned w);
    int unsigned m;
    int unsigned lim;
    lim = (32'd1 << (w - 1)) - 32'd1;
    m   = (v < 0) ? 32'(-v) : 32'(v);
    return (m > lim) ? lim : m;
  endfunction

endpackage

// File: rtl/afe_agc_loop.sv
// Windowed peak-detect AGC: tracks the peak magnitude of strobed samples and
// steps a thermometer-coded VGA gain index once per window.
module afe_agc_loop
  import afe_pkg::*;
#(
  parameter int unsigned ADC_W     = 8,
  parameter int unsigned VGA_STEPS = 6,
  parameter int unsigned GAIN_INIT = 3,
  parameter int unsigned AGC_WIN   = 16,
  parameter int unsigned HI_TH     = 96,
  parameter int unsigned LO_TH     = 24
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               agc_en,
  input  logic [ADC_W-1:0]                   sample_in,
  input  logic                               sample_valid,
  output logic [$clog2(VGA_STEPS+1)-1:0]     gain_idx,
  output logic [VGA_STEPS-1:0]               vga_ctrl
);

  localparam int unsigned GW   = $clog2(VGA_STEPS + 1);
  localparam int unsigned PK_W = ADC_W - 1;
  localparam int unsigned WC_W = $clog2(AGC_WIN + 1);

  logic [PK_W-1:0]      peak_q, peak_d;
  logic [WC_W-1:0]      wcnt_q, wcnt_d;
  logic [GW-1:0]        gain_q, gain_d;
  logic [VGA_STEPS-1:0] vga_q, vga_d;
  int unsigned          mag;
  int unsigned          pk;

  always_comb begin
    peak_d = peak_q;
    wcnt_d = wcnt_q;
    gain_d = gain_q;
    mag    = sat_abs(32'($signed(sample_in)), ADC_W);
    pk     = (mag > 32'(peak_q)) ? mag : 32'(peak_q);
    if (sample_valid) begin
      // Window end decides on the peak including this sample, then clears.
      if (32'(wcnt_q) + 32'd1 == AGC_WIN) begin
        peak_d = '0;
        wcnt_d = '0;
        if (agc_en) begin
          if (pk >= HI_TH && gain_q != '0) begin
            gain_d = gain_q - GW'(1);
          end else if (pk < LO_TH && 32'(gain_q) < VGA_STEPS) begin
            gain_d = gain_q + GW'(1);
          end
        end
      end else begin
        peak_d = PK_W'(pk);
        wcnt_d = wcnt_q + WC_W'(1);
      end
    end
    vga_d = VGA_STEPS'(thermometer(32'(gain_d), VGA_STEPS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
      wcnt_q <= '0;
      gain_q <= GW'(GAIN_INIT);
      vga_q  <= VGA_STEPS'(thermometer(GAIN_INIT, VGA_STEPS));
    end else begin
      peak_q <= peak_d;
      wcnt_q <= wcnt_d;
      gain_q <= gain_d;
      vga_q  <= vga_d;
    end
  end

  assign gain_idx = gain_q;
  assign vga_ctrl = vga_q;

endmodule

// File: rtl/afe_sar_agc_ctrl.sv
// AFE controller: SAR conversion sequencer with offset-binary to two's
// complement output, feeding the AGC loop. Optional: AFE_SAR_AGC_CTRL_CLIP_CNT_EN.
module afe_sar_agc_ctrl
  import afe_pkg::*;
#(
  parameter int unsigned ADC_W         = 8,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned VGA_STEPS     = 6,
  parameter int unsigned GAIN_INIT     = 3,
  parameter int unsigned AGC_WIN       = 16,
  parameter int unsigned HI_TH         = 96,
  parameter int unsigned LO_TH         = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           agc_en,
  input  logic                           cmp,
  output logic                           o_vin_ctrl,
  output logic [ADC_W-1:0]               o_vref_ctrl,
  output logic [ADC_W-1:0]               sample_out,
  output logic                           sample_valid,
  output logic                           busy,
  output logic [$clog2(VGA_STEPS+1)-1:0] gain_idx,
  output logic [VGA_STEPS-1:0]           vga_ctrl
`ifdef AFE_SAR_AGC_CTRL_CLIP_CNT_EN
  ,
  output logic [15:0]                    clip_cnt
`endif
);

  localparam int unsigned CNT_MAX = (SAMPLE_CYCLES > ADC_W) ? SAMPLE_CYCLES : ADC_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADC_W-1:0] MSB = {1'b1, {(ADC_W-1){1'b0}}};

  afe_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADC_W-1:0] dec_q, dec_d;
  logic [ADC_W-1:0] sout_q, sout_d;
  logic [ADC_W-1:0] trial;

  // cnt_q counts sample cycles in SAMPLE and holds the bit index in CONVERT.
  assign trial = dec_q | (ADC_W'(1) << cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dec_q   <= '0;
      sout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      sout_q  <= sout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    sout_d  = sout_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d = CONVERT;
          cnt_d   = CNT_W'(ADC_W - 1);
          dec_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CONVERT: begin
        if (cmp) dec_d = trial;
        if (cnt_q == '0) begin
          state_d = DONE;
          sout_d  = (cmp ? trial : dec_q) ^ MSB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = en ? SAMPLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_vin_ctrl   = 1'b0;
    o_vref_ctrl  = '0;
    sample_valid = 1'b0;
    busy         = 1'b1;
    unique case (state_q)
      IDLE:    busy         = 1'b0;
      SAMPLE:  o_vin_ctrl   = 1'b1;
      CONVERT: o_vref_ctrl  = trial;
      DONE:    sample_valid = 1'b1;
      default: busy         = 1'b0;
    endcase
  end

  assign sample_out = sout_q;

`ifdef AFE_SAR_AGC_CTRL_CLIP_CNT_EN
  logic [15:0]      clip_q, clip_d;
  logic [ADC_W-1:0] raw;

  always_comb begin
    raw    = sout_q ^ MSB;
    clip_d = clip_q;
    if (state_q == DONE && (raw == '0 || raw == '1) && clip_q != 16'hFFFF) begin
      clip_d = clip_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clip_q <= '0;
    else        clip_q <= clip_d;
  end

  assign clip_cnt = clip_q;
`endif

  afe_agc_loop #(
    .ADC_W     (ADC_W),
    .VGA_STEPS (VGA_STEPS),
    .GAIN_INIT (GAIN_INIT),
    .AGC_WIN   (AGC_WIN),
    .HI_TH     (HI_TH),
    .LO_TH     (LO_TH)
  ) u_agc (
    .clk          (clk),
    .rst_n        (rst_n),
    .agc_en       (agc_en),
    .sample_in    (sout_q),
    .sample_valid (sample_valid),
    .gain_idx     (gain_idx),
    .vga_ctrl     (vga_ctrl)
  );

endmodule

// File: tb/tb_afe_sar_agc_ctrl.sv
// Bench for afe_sar_agc_ctrl: behavioural timing/AGC model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_afe_sar_agc_ctrl;

  localparam int W   = 8;
  localparam int SC  = 2;
  localparam int VS  = 6;
  localparam int GI  = 3;
  localparam int WIN = 4;
  localparam int HI  = 96;
  localparam int LO  = 24;
  localparam int P   = SC + W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         agc_en = 1'b1;
  logic         cmp;
  logic [W-1:0] vin_code = '0;
  logic         o_vin_ctrl;
  logic [W-1:0] o_vref_ctrl;
  logic [W-1:0] sample_out;
  logic         sample_valid;
  logic         busy;
  logic [2:0]   gain_idx;
  logic [VS-1:0] vga_ctrl;
`ifdef AFE_SAR_AGC_CTRL_CLIP_CNT_EN
  logic [15:0]  clip_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Analog input modelled at mid-code, so a trial equal to the code reads as "above".
  assign cmp = (vin_code >= o_vref_ctrl);

  afe_sar_agc_ctrl #(
    .ADC_W         (W),
    .SAMPLE_CYCLES (SC),
    .VGA_STEPS     (VS),
    .GAIN_INIT     (GI),
    .AGC_WIN       (WIN),
    .HI_TH         (HI),
    .LO_TH         (LO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .agc_en       (agc_en),
    .cmp          (cmp),
    .o_vin_ctrl   (o_vin_ctrl),
    .o_vref_ctrl  (o_vref_ctrl),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .gain_idx     (gain_idx),
    .vga_ctrl     (vga_ctrl)
`ifdef AFE_SAR_AGC_CTRL_CLIP_CNT_EN
    ,
    .clip_cnt     (clip_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phase 0 = idle; 1..SC sample; SC+1..SC+W bit trials MSB first; P = strobe.
  int           m_phase = 0;
  int           m_gain  = GI;
  int           m_peak  = 0;
  int           m_cnt   = 0;
  int           m_clip  = 0;
  logic [W-1:0] m_out   = '0;

  always @(posedge clk or negedge rst_n) begin
    int s, mag;
    if (!rst_n) begin
      m_phase = 0; m_gain = GI; m_peak = 0; m_cnt = 0; m_clip = 0; m_out = '0;
    end else if (m_phase == 0) begin
      if (en) m_phase = 1;
    end else if (m_phase == P) begin
      s   = m_out[W-1] ? int'(m_out) - (1 << W) : int'(m_out);
      mag = (s < 0) ? -s : s;
      if (mag > (1 << (W-1)) - 1) mag = (1 << (W-1)) - 1;
      if (mag > m_peak) m_peak = mag;
      m_cnt++;
      if (m_cnt == WIN) begin
        if (agc_en) begin
          if (m_peak >= HI && m_gain > 0) m_gain--;
          else if (m_peak < LO && m_gain < VS) m_gain++;
        end
        m_peak = 0;
        m_cnt  = 0;
      end
      if (((m_out ^ 8'h80) == 8'h00 || (m_out ^ 8'h80) == 8'hFF) && m_clip < 65535) m_clip++;
      m_phase = en ? 1 : 0;
    end else begin
      m_phase++;
      if (m_phase == P) m_out = vin_code ^ 8'h80;
    end
  end

  always @(negedge clk) begin
    int i;
    logic [31:0] e_vref, v;
    e_vref = 0;
    if (m_phase > SC && m_phase <= SC + W) begin
      i = W - 1 - (m_phase - SC - 1);
      v = 32'(vin_code);
      e_vref = ((v >> (i + 1)) << (i + 1)) | (32'd1 << i);
    end
    chk("vin_ctrl", 32'(o_vin_ctrl), 32'(m_phase >= 1 && m_phase <= SC));
    chk("vref_ctrl", 32'(o_vref_ctrl), e_vref);
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("sample_valid", 32'(sample_valid), 32'(m_phase == P));
    chk("sample_out", 32'(sample_out), 32'(m_out));
    chk("gain_idx", 32'(gain_idx), 32'(m_gain));
    chk("vga_ctrl", 32'(vga_ctrl), (32'd1 << m_gain) - 32'd1);
`ifdef AFE_SAR_AGC_CTRL_CLIP_CNT_EN
    chk("clip_cnt", 32'(clip_cnt), 32'(m_clip));
`endif
  end

  // ---------------- trial capture ----------------
  logic         capture = 1'b0;
  int           ntr = 0;
  logic [W-1:0] trials [16];

  always @(negedge clk) begin
    if (!capture) ntr = 0;
    else if (busy && !o_vin_ctrl && !sample_valid && ntr < 16) begin
      trials[ntr] = o_vref_ctrl;
      ntr++;
    end
  end

  // ---------------- directed helpers ----------------
  logic [W-1:0]  out_hist  [32];
  int            strobe_cyc[32];
  logic [2:0]    gain_hist [32];
  logic [VS-1:0] vga_hist  [32];
  logic          busy_hist [32];

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("strobe_wait");
  endtask

  // Call at a negedge with the DUT idle; vin alternates v0/v1 per sample.
  task automatic do_samples(input int n, input logic [W-1:0] v0, input logic [W-1:0] v1);
    bit ok;
    vin_code = v0;
    en = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_strobe(ok);
      if (!ok) break;
      out_hist[k]   = sample_out;
      strobe_cyc[k] = cyc;
      vin_code = ((k + 1) % 2 == 0) ? v0 : v1;
      if (k == n - 1) en = 1'b0;
      @(negedge clk);
      gain_hist[k] = gain_idx;
      vga_hist[k]  = vga_ctrl;
      busy_hist[k] = busy;
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [W-1:0] exp_tr [8];
  int           c0;
  int           nstrobe;

  initial begin
    exp_tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    repeat (3) @(negedge clk);
    chk("rst_gain", 32'(gain_idx), 32'd3);
    chk("rst_vga", 32'(vga_ctrl), 32'b000111);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", 32'(sample_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic conversion
    capture = 1'b1;
    c0 = cyc;
    do_samples(1, 8'hA5, 8'hA5);
    chk("basic_latency", 32'(strobe_cyc[0] - c0), 32'd11);
    chk("basic_out", 32'(out_hist[0]), 32'h25);
    chk("basic_busy_drop", 32'(busy_hist[0]), 32'd0);
    chk("basic_ntrials", 32'(ntr), 32'd8);
    for (int i = 0; i < 8; i++) chk("basic_trial", 32'(trials[i]), 32'(exp_tr[i]));
    capture = 1'b0;

    // Back-to-back and midpoint
    do_samples(4, 8'h00, 8'hFF);
    for (int k = 1; k < 4; k++) chk("b2b_period", 32'(strobe_cyc[k] - strobe_cyc[k-1]), 32'd11);
    for (int k = 0; k < 4; k++) chk("b2b_out", 32'(out_hist[k]), (k % 2 == 0) ? 32'h80 : 32'h7F);
    do_samples(1, 8'h80, 8'h80);
    chk("mid_out", 32'(out_hist[0]), 32'h00);

    // AGC down then up
    do_reset();
    agc_en = 1'b1;
    do_samples(16, 8'hFF, 8'hFF);
    chk("agc_dn_s3", 32'(gain_hist[2]), 32'd3);
    chk("agc_dn_s4", 32'(gain_hist[3]), 32'd2);
    chk("agc_dn_s8", 32'(gain_hist[7]), 32'd1);
    chk("agc_dn_s12", 32'(gain_hist[11]), 32'd0);
    chk("agc_dn_s16", 32'(gain_hist[15]), 32'd0);
    chk("agc_dn_vga4", 32'(vga_hist[3]), 32'b000011);
    chk("agc_dn_vga8", 32'(vga_hist[7]), 32'b000001);
    chk("agc_dn_vga12", 32'(vga_hist[11]), 32'b000000);
    do_samples(28, 8'h82, 8'h82);
    for (int k = 0; k < 7; k++) chk("agc_up", 32'(gain_hist[k*4+3]), (k < 6) ? 32'(k + 1) : 32'd6);
    chk("agc_up_vga", 32'(vga_hist[27]), 32'b111111);

    // Freeze and hysteresis
    do_reset();
    agc_en = 1'b0;
    do_samples(8, 8'hFF, 8'hFF);
    chk("freeze_gain", 32'(gain_hist[7]), 32'd3);
    agc_en = 1'b1;
    do_samples(8, 8'hB2, 8'hB2);
    chk("hyst_out", 32'(out_hist[0]), 32'h32);
    chk("hyst_gain4", 32'(gain_hist[3]), 32'd3);
    chk("hyst_gain8", 32'(gain_hist[7]), 32'd3);

    // Async reset during CONVERT bit 4
    vin_code = 8'h5A;
    en = 1'b1;
    c0 = 0;
    while (!(busy && !o_vin_ctrl) && c0 < 20) begin
      @(negedge clk);
      c0++;
    end
    if (c0 >= 20) fail_now("reset_mid_reach");
    repeat (3) @(negedge clk);
    chk("reset_mid_bit4", 32'(o_vref_ctrl[4:0]), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_busy", 32'(busy), 32'd0);
    chk("reset_mid_vref", 32'(o_vref_ctrl), 32'd0);
    chk("reset_mid_out", 32'(sample_out), 32'd0);
    chk("reset_mid_gain", 32'(gain_idx), 32'd3);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nstrobe = 0;
    repeat (20) begin
      @(negedge clk);
      if (sample_valid) nstrobe++;
    end
    chk("reset_mid_nostrobe", 32'(nstrobe), 32'd0);

    // en dropped mid-conversion
    vin_code = 8'h3C;
    en = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    nstrobe = 0;
    repeat (30) begin
      @(negedge clk);
      if (sample_valid) begin
        nstrobe++;
        chk("endrop_out", 32'(sample_out), 32'hBC);
      end
    end
    chk("endrop_strobes", 32'(nstrobe), 32'd1);
    chk("endrop_idle", 32'(busy), 32'd0);

`ifdef AFE_SAR_AGC_CTRL_CLIP_CNT_EN
    do_reset();
    do_samples(3, 8'hFF, 8'hFF);
    do_samples(2, 8'h00, 8'h00);
    chk("clip_cnt5", 32'(clip_cnt), 32'd5);
`endif

    // Randomised traffic, vin only changes between conversions
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) agc_en = ~agc_en;
      if (!busy || sample_valid) begin
        case ($urandom_range(0, 3))
          0: vin_code = W'($urandom_range(0, 255));
          1: vin_code = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
          default: vin_code = W'(8'h80 + $urandom_range(0, 40) - 20);
        endcase
      end
    end
    en = 1'b0;
    repeat (15) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
